// File: rtl/mgt_01_iter_divider_pkg.sv
// Shared types for the MicroGT-01 iterative divider.
//   div_ops_e  : RISC-V M-extension divide/remainder opcodes
//   fu_state_e : functional-unit occupancy reported to the issue logic
//   div_fsm_e  : divider control states
package mgt_01_iter_divider_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StRestore,
    StDone
  } div_fsm_e;

  function automatic logic is_signed_op(input div_ops_e op);
    return (op == DIV_) || (op == REM_);
  endfunction

  function automatic logic is_rem_op(input div_ops_e op);
    return (op == REM_) || (op == REMU_);
  endfunction

endpackage

// File: rtl/mgt_01_div_step.sv
// One radix-2 non-restoring division iteration, purely combinational.
//   pa_i : current {P, A}; P is DATA_W+1 bits (two's complement), A is DATA_W bits
//   b_i  : divisor magnitude, zero-extended to DATA_W+1 bits
//   pa_o : {P, A} after shifting left, adding/subtracting B and inserting the quotient bit
module mgt_01_div_step
  import mgt_01_iter_divider_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W:0] pa_i,
  input  logic [DATA_W:0]   b_i,
  output logic [2*DATA_W:0] pa_o
);

  logic [DATA_W:0] p_sh;
  logic [DATA_W:0] p_new;

  always_comb begin
    // {P,A} << 1 restricted to the P field: old P low bits plus the A msb.
    p_sh = pa_i[2*DATA_W-1:DATA_W-1];
    // A negative partial remainder is corrected by adding B on the next step
    // instead of restoring it now.
    if (pa_i[2*DATA_W]) begin
      p_new = p_sh + b_i;
    end else begin
      p_new = p_sh - b_i;
    end
    pa_o = {p_new, pa_i[DATA_W-2:0], ~p_new[DATA_W]};
  end

endmodule

// File: rtl/mgt_01_iter_divider.sv
// MicroGT-01 multi-cycle integer divider (RISC-V DIV/DIVU/REM/REMU).
// Radix-2 non-restoring core, one quotient bit per enabled cycle, with
// valid/ready handshakes on both sides, a flush input and a global stall.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   clk_en_i              global stall; low freezes all state (kill_i excepted)
//   kill_i                pipeline flush, aborts any operation in flight
//   valid_i / ready_o     request handshake; ready_o high only in idle
//   dividend_i, divisor_i operands, latched on accept
//   operation_i           DIV_/DIVU_/REM_/REMU_
//   valid_o / ready_i     result handshake; result held until accepted
//   result_o              quotient or remainder
//   zero_divide_o         divisor was zero (qualified by valid_o)
//   overflow_o            signed MIN / -1 (qualified by valid_o)
//   fu_state_o            FREE in idle, BUSY otherwise
//
// Build option: define MGT_DIV_EARLY_OUT_EN to return divide-by-zero and
// signed-overflow results on the cycle after accept instead of running the
// full iteration sequence. Results and flags are identical either way.
module mgt_01_iter_divider
  import mgt_01_iter_divider_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clk_en_i,
  input  logic              kill_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  div_ops_e          operation_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_divide_o,
  output logic              overflow_o,
  output fu_state_e         fu_state_o
);

  localparam int unsigned       CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MinVal  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] AllOnes = '1;

  // {P, A} register pair: P is the signed partial remainder, A collects the quotient.
  typedef struct packed {
    logic [DATA_W:0]   p;
    logic [DATA_W-1:0] a;
  } pa_t;

  div_fsm_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  div_ops_e          op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  pa_t               pa_q, pa_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] dividend_q, dividend_d;
  logic              req_zero_q, req_zero_d;
  logic              req_ovf_q, req_ovf_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_div_q, zero_div_d;
  logic              ovf_q, ovf_d;

  logic [2*DATA_W:0] pa_step;

  // Accept-side operand decode.
  logic              acc_signed;
  logic              acc_sign_a;
  logic              acc_sign_b;
  logic [DATA_W-1:0] acc_abs_a;
  logic [DATA_W-1:0] acc_abs_b;
  logic              acc_zero;
  logic              acc_ovf;

  // Restore-side result assembly.
  logic [DATA_W-1:0] rem_mag;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] core_result;

  // Architectural results for the cases the core does not define by itself.
  function automatic logic [DATA_W-1:0] corner_result(input div_ops_e          op,
                                                      input logic [DATA_W-1:0] dividend,
                                                      input logic              zero);
    if (zero) begin
      return is_rem_op(op) ? dividend : AllOnes;
    end
    return is_rem_op(op) ? '0 : MinVal;
  endfunction

  mgt_01_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .pa_i (pa_q),
    .b_i  ({1'b0, b_q}),
    .pa_o (pa_step)
  );

  always_comb begin
    acc_signed = is_signed_op(operation_i);
    acc_sign_a = acc_signed & dividend_i[DATA_W-1];
    acc_sign_b = acc_signed & divisor_i[DATA_W-1];
    acc_abs_a  = acc_sign_a ? -dividend_i : dividend_i;
    acc_abs_b  = acc_sign_b ? -divisor_i : divisor_i;
    acc_zero   = (divisor_i == '0);
    acc_ovf    = acc_signed && (dividend_i == MinVal) && (divisor_i == AllOnes);
  end

  always_comb begin
    // Final correction of a negative remainder; modulo 2^DATA_W is enough
    // because the corrected value always lies in [0, B).
    rem_mag     = pa_q.p[DATA_W] ? (pa_q.p[DATA_W-1:0] + b_q) : pa_q.p[DATA_W-1:0];
    // Sign flags are only ever set for signed ops, so no op check is needed here.
    quo_fix     = (sign_a_q ^ sign_b_q) ? -pa_q.a : pa_q.a;
    rem_fix     = sign_a_q ? -rem_mag : rem_mag;
    core_result = is_rem_op(op_q) ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    pa_d       = pa_q;
    b_d        = b_q;
    dividend_d = dividend_q;
    req_zero_d = req_zero_q;
    req_ovf_d  = req_ovf_q;
    valid_d    = valid_q;
    result_d   = result_q;
    zero_div_d = zero_div_q;
    ovf_d      = ovf_q;

    if (kill_i) begin
      state_d = StIdle;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (clk_en_i) begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            op_d       = operation_i;
            sign_a_d   = acc_sign_a;
            sign_b_d   = acc_sign_b;
            pa_d.p     = '0;
            pa_d.a     = acc_abs_a;
            b_d        = acc_abs_b;
            dividend_d = dividend_i;
            req_zero_d = acc_zero;
            req_ovf_d  = acc_ovf;
            cnt_d      = '0;
`ifdef MGT_DIV_EARLY_OUT_EN
            if (acc_zero || acc_ovf) begin
              result_d   = corner_result(operation_i, dividend_i, acc_zero);
              zero_div_d = acc_zero;
              ovf_d      = acc_ovf;
              valid_d    = 1'b1;
              state_d    = StDone;
            end else begin
              state_d = StDivide;
            end
`else
            state_d = StDivide;
`endif
          end
        end
        StDivide: begin
          pa_d = pa_step;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StRestore;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRestore: begin
          result_d   = (req_zero_q || req_ovf_q) ? corner_result(op_q, dividend_q, req_zero_q)
                                                 : core_result;
          zero_div_d = req_zero_q;
          ovf_d      = req_ovf_q;
          valid_d    = 1'b1;
          state_d    = StDone;
        end
        StDone: begin
          if (ready_i) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= DIV_;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      pa_q       <= '0;
      b_q        <= '0;
      dividend_q <= '0;
      req_zero_q <= 1'b0;
      req_ovf_q  <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_div_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      pa_q       <= pa_d;
      b_q        <= b_d;
      dividend_q <= dividend_d;
      req_zero_q <= req_zero_d;
      req_ovf_q  <= req_ovf_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_div_q <= zero_div_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ready_o       = (state_q == StIdle);
  assign fu_state_o    = (state_q == StIdle) ? FREE : BUSY;
  assign valid_o       = valid_q;
  assign result_o      = result_q;
  assign zero_divide_o = zero_div_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_mgt_01_iter_divider.sv
// Directed self-checking bench for mgt_01_iter_divider (DATA_W = 32).
module tb_mgt_01_iter_divider;
  import mgt_01_iter_divider_pkg::*;

  localparam int LatFull = 34;
`ifdef MGT_DIV_EARLY_OUT_EN
  localparam int LatCorner = 1;
`else
  localparam int LatCorner = 34;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        kill_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  div_ops_e    operation_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_divide_o;
  logic        overflow_o;
  fu_state_e   fu_state_o;

  int n_checks = 0;
  int n_errors = 0;

  mgt_01_iter_divider #(
    .DATA_W (32)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .clk_en_i      (clk_en_i),
    .kill_i        (kill_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .operation_i   (operation_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .zero_divide_o (zero_divide_o),
    .overflow_o    (overflow_o),
    .fu_state_o    (fu_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operands.
  task automatic start_op(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
    valid_i     = 1'b1;
    operation_i = op;
    dividend_i  = a;
    divisor_i   = b;
    @(posedge clk_i);
    #1;
    valid_i     = 1'b0;
    operation_i = REMU_;
    dividend_i  = $urandom;
    divisor_i   = $urandom;
  endtask

  // Count edges from the accept edge (inclusive) until valid_o; optionally
  // stall clk_en_i for 3 edges starting after edge stall_at.
  task automatic wait_valid(input int stall_at, output int lat);
    lat = 1;
    while (!valid_o && lat < 200) begin
      if (lat == stall_at) clk_en_i = 1'b0;
      if (lat == stall_at + 3) clk_en_i = 1'b1;
      @(posedge clk_i);
      #1;
      lat++;
    end
    clk_en_i = 1'b1;
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input div_ops_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zd,
                       input logic exp_ov, input int exp_lat, input int stall_at);
    int lat;
    start_op(op, a, b);
    check({tag, "_busy"}, 32'(ready_o), 32'd0);
    wait_valid(stall_at, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_zd"}, 32'(zero_divide_o), 32'(exp_zd));
    check({tag, "_ov"}, 32'(overflow_o), 32'(exp_ov));
    consume();
    check({tag, "_drop"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n_i     = 1'b0;
    clk_en_i    = 1'b1;
    kill_i      = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    dividend_i  = '0;
    divisor_i   = '0;
    operation_i = DIV_;
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zd", 32'(zero_divide_o), 32'd0);
    check("rst_ov", 32'(overflow_o), 32'd0);
    check("rst_fu", 32'(fu_state_o), 32'(FREE));

    do_op("divu_100_7", DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, LatFull, 0);
    do_op("remu_100_7", REMU_, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, LatFull, 0);
    do_op("div_m100_7", DIV_, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 1'b0, LatFull, 0);
    do_op("rem_m100_7", REM_, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, LatFull, 0);
    do_op("rem_100_m7", REM_, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, LatFull, 0);
    do_op("div_100_m7", DIV_, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 1'b0, LatFull, 0);
    do_op("divu_7_100", DIVU_, 32'd7, 32'd100, 32'd0, 1'b0, 1'b0, LatFull, 0);
    do_op("divu_max_1", DIVU_, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, LatFull, 0);
    do_op("remu_max_msb", REMU_, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0,
          LatFull, 0);
    do_op("div_ovf", DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1,
          LatCorner, 0);
    do_op("rem_ovf", REM_, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, LatCorner, 0);
    do_op("divu_dz", DIVU_, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, LatCorner, 0);
    do_op("remu_dz", REMU_, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1, 1'b0, LatCorner, 0);
    do_op("div_m100_dz", DIV_, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, LatCorner, 0);
    do_op("rem_m100_dz", REM_, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1'b1, 1'b0, LatCorner, 0);

    // Stall for 3 edges mid-DIVIDE: latency grows by exactly 3.
    do_op("stall", DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, LatFull + 3, 10);

    // Result held while the consumer back-pressures.
    start_op(DIVU_, 32'd100, 32'd7);
    wait_valid(0, lat);
    check("hold_lat", lat, LatFull);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      check("hold_res", result_o, 32'd14);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_ready", 32'(ready_o), 32'd0);
    end
    // No handshake while stalled.
    clk_en_i = 1'b0;
    ready_i  = 1'b1;
    @(posedge clk_i);
    #1;
    check("done_stall_valid", 32'(valid_o), 32'd1);
    clk_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check("done_ack_valid", 32'(valid_o), 32'd0);
    check("done_ack_ready", 32'(ready_o), 32'd1);

    // Flush mid-DIVIDE, then a fresh request.
    start_op(DIVU_, 32'd100, 32'd7);
    repeat (9) @(posedge clk_i);
    #1;
    check("kill_pre_fu", 32'(fu_state_o), 32'(BUSY));
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    check("kill_valid", 32'(valid_o), 32'd0);
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_fu", 32'(fu_state_o), 32'(FREE));
    do_op("after_kill", DIVU_, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0, LatFull, 0);

    // Flush with a stall still takes effect.
    start_op(DIVU_, 32'd50, 32'd5);
    clk_en_i = 1'b0;
    kill_i   = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i   = 1'b0;
    clk_en_i = 1'b1;
    check("kill_stall_ready", 32'(ready_o), 32'd1);

    // Flush in IDLE blocks a simultaneous request.
    kill_i      = 1'b1;
    valid_i     = 1'b1;
    operation_i = DIVU_;
    dividend_i  = 32'd9;
    divisor_i   = 32'd3;
    @(posedge clk_i);
    #1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    check("kill_idle_ready", 32'(ready_o), 32'd1);
    check("kill_idle_fu", 32'(fu_state_o), 32'(FREE));

    // Flush while a result waits for the consumer.
    start_op(DIVU_, 32'd9, 32'd3);
    wait_valid(0, lat);
    check("kill_done_pre", 32'(valid_o), 32'd1);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    check("kill_done_valid", 32'(valid_o), 32'd0);
    check("kill_done_ready", 32'(ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
